// File: rtl/lcd_pkg.sv
// lcd_pkg: shared definitions for the TFT pixel-source blocks.
//   - RGB565 colour constants.
//   - Pattern mode encodings (0-4; 5-7 render black).
//   - bar_color(): colour of each of the eight colour bars.
//   - next_auto_mode(): successor mode when auto-cycling patterns.
package lcd_pkg;

  localparam logic [15:0] BLACK   = 16'h0000;
  localparam logic [15:0] WHITE   = 16'hFFFF;
  localparam logic [15:0] RED     = 16'hF800;
  localparam logic [15:0] GREEN   = 16'h07E0;
  localparam logic [15:0] BLUE    = 16'h001F;
  localparam logic [15:0] CYAN    = 16'h07FF;
  localparam logic [15:0] MAGENTA = 16'hF81F;
  localparam logic [15:0] YELLOW  = 16'hFFE0;

  typedef enum logic [2:0] {
    MODE_SOLID    = 3'd0,
    MODE_BARS     = 3'd1,
    MODE_CHECKER  = 3'd2,
    MODE_GRADIENT = 3'd3,
    MODE_BORDER   = 3'd4
  } pattern_mode_e;

  // Bars run left to right: white, yellow, cyan, green, magenta, red, blue, black.
  function automatic logic [15:0] bar_color(input logic [2:0] idx);
    logic [15:0] c;
    c = BLACK;
    case (idx)
      3'd0:    c = WHITE;
      3'd1:    c = YELLOW;
      3'd2:    c = CYAN;
      3'd3:    c = GREEN;
      3'd4:    c = MAGENTA;
      3'd5:    c = RED;
      3'd6:    c = BLUE;
      default: c = BLACK;
    endcase
    return c;
  endfunction

  // 0->1->2->3->4->0; any out-of-range mode also restarts at solid.
  function automatic logic [2:0] next_auto_mode(input logic [2:0] m);
    logic [2:0] n;
    if (m >= MODE_BORDER) n = MODE_SOLID;
    else                  n = m + 3'd1;
    return n;
  endfunction

endpackage

// File: rtl/lcd_bar_index.sv
// lcd_bar_index: maps an X coordinate to one of eight equal-width vertical
// bars of a line WIDTH pixels wide, using a comparator chain against
// constant thresholds (no divider). Columns past 8*(WIDTH/8) map to bar 7.
// Ports:
//   x_i    in  16  pixel X coordinate
//   bar_o  out  3  bar index 0..7
module lcd_bar_index #(
  parameter int unsigned WIDTH = 320
) (
  input  logic [15:0] x_i,
  output logic [2:0]  bar_o
);

  localparam int unsigned BAR_W = WIDTH / 8;

  // Scanning thresholds from the right keeps the smallest matching bar.
  always_comb begin
    bar_o = 3'd7;
    for (int unsigned i = 7; i > 0; i--) begin
      if ({16'd0, x_i} < BAR_W * i) bar_o = 3'(i - 1);
    end
  end

endmodule

// File: rtl/lcd_pattern_gen.sv
// lcd_pattern_gen: test-pattern pixel source for the SPI TFT driver.
// Returns an RGB565 word for the coordinate presented by the driver, two
// registered stages after the coordinate changes. Pattern selection and the
// frame counter only change at the last-pixel request of a frame.
// Optional feature macro: PATTERN_AUTO_CYCLE_EN -- when defined, mode_i is
// ignored and the pattern steps 0..4 every FRAMES_PER_MODE frames.
// Ports:
//   sys_clk       in   1  system clock
//   sys_rst_n     in   1  asynchronous active-low reset
//   pix_req_i     in   1  pixel consumed; coordinates advance next cycle
//   x_i, y_i      in  16  current pixel coordinate
//   mode_i        in   3  requested pattern (sampled at frame boundaries)
//   pix_data_o    out 16  RGB565 pixel
//   frame_done_o  out  1  one-cycle pulse after the last pixel request
//   frame_cnt_o   out 16  completed-frame count (wraps)
//   mode_o        out  3  active pattern
module lcd_pattern_gen
  import lcd_pkg::*;
#(
  parameter int unsigned SCREEN_WIDTH    = 320,
  parameter int unsigned SCREEN_HEIGHT   = 240,
  parameter logic [15:0] FILL_COLOR      = 16'hF800,
  parameter int unsigned CHK_SHIFT       = 4,
  parameter int unsigned FRAMES_PER_MODE = 16
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        pix_req_i,
  input  logic [15:0] x_i,
  input  logic [15:0] y_i,
  input  logic [2:0]  mode_i,
  output logic [15:0] pix_data_o,
  output logic        frame_done_o,
  output logic [15:0] frame_cnt_o,
  output logic [2:0]  mode_o
);

  localparam logic [15:0] X_LAST = 16'(SCREEN_WIDTH - 1);
  localparam logic [15:0] Y_LAST = 16'(SCREEN_HEIGHT - 1);
  localparam logic [15:0] X_LIM  = 16'(SCREEN_WIDTH);
  localparam logic [15:0] Y_LIM  = 16'(SCREEN_HEIGHT);

  logic last_pix;
  assign last_pix = pix_req_i && (x_i == X_LAST) && (y_i == Y_LAST);

  // ---------------------------------------------------------------- frame state
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      frame_done_o <= 1'b0;
      frame_cnt_o  <= '0;
    end else begin
      frame_done_o <= last_pix;
      if (last_pix) frame_cnt_o <= frame_cnt_o + 16'd1;
    end
  end

`ifdef PATTERN_AUTO_CYCLE_EN
  localparam int unsigned FPM_W = (FRAMES_PER_MODE > 2) ? $clog2(FRAMES_PER_MODE) : 1;

  logic [FPM_W-1:0] fpm_cnt;
  logic [2:0]       unused_mode;
  assign unused_mode = mode_i;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      fpm_cnt <= '0;
      mode_o  <= MODE_SOLID;
    end else if (last_pix) begin
      if (fpm_cnt == FPM_W'(FRAMES_PER_MODE - 1)) begin
        fpm_cnt <= '0;
        mode_o  <= next_auto_mode(mode_o);
      end else begin
        fpm_cnt <= fpm_cnt + 1'b1;
      end
    end
  end
`else
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)    mode_o <= MODE_SOLID;
    else if (last_pix) mode_o <= mode_i;
  end
`endif

  // ---------------------------------------------------------------- stage 1
  logic [15:0] s1_x, s1_y;
  logic [2:0]  s1_mode;
  logic [4:0]  s1_fc;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      s1_x    <= '0;
      s1_y    <= '0;
      s1_mode <= '0;
      s1_fc   <= '0;
    end else begin
      s1_x    <= x_i;
      s1_y    <= y_i;
      s1_mode <= mode_o;
      s1_fc   <= frame_cnt_o[4:0];
    end
  end

  // ---------------------------------------------------------------- stage 2
  logic [2:0]  bar_idx;
  logic [15:0] pix_next;
  logic        in_range;
  logic        on_border;

  lcd_bar_index #(.WIDTH(SCREEN_WIDTH)) u_bar_index (
    .x_i   (s1_x),
    .bar_o (bar_idx)
  );

  assign in_range  = (s1_x < X_LIM) && (s1_y < Y_LIM);
  assign on_border = (s1_x == 16'd0) || (s1_x == X_LAST) ||
                     (s1_y == 16'd0) || (s1_y == Y_LAST);

  always_comb begin
    pix_next = BLACK;
    if (in_range) begin
      case (s1_mode)
        MODE_SOLID:    pix_next = FILL_COLOR;
        MODE_BARS:     pix_next = bar_color(bar_idx);
        MODE_CHECKER:  pix_next = (s1_x[CHK_SHIFT] ^ s1_y[CHK_SHIFT]) ? WHITE : BLACK;
        MODE_GRADIENT: pix_next = {s1_x[7:3], s1_y[7:2], s1_fc};
        MODE_BORDER:   pix_next = on_border ? WHITE : BLACK;
        default:       pix_next = BLACK;
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) pix_data_o <= '0;
    else            pix_data_o <= pix_next;
  end

endmodule
